// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage: load extraction, writeback-source
// selection, register-file write port, EX forwarding mirror and retired-instruction count.
module mem_wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [15:0]      sw_i,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_RegWrite,
    input  logic [1:0]       in_WDSel,
    input  logic [2:0]       in_DMType,
    input  logic [31:0]      in_alu,
    input  logic [31:0]      in_mem_word,
    input  logic [31:0]      in_pc,
    input  logic [4:0]       in_rd,
    output logic             RFWr,
    output logic [4:0]       A3,
    output logic [31:0]      WD,
    output logic             wb_valid,
    output logic             fwd_en,
    output logic [4:0]       fwd_rd,
    output logic [31:0]      fwd_data,
    output logic             misalign,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [1:0] WDSEL_MEM = 2'b01;
    localparam logic [1:0] WDSEL_PC4 = 2'b10;

    localparam logic [2:0] DM_LH  = 3'b001;
    localparam logic [2:0] DM_LHU = 3'b010;
    localparam logic [2:0] DM_LB  = 3'b011;
    localparam logic [2:0] DM_LBU = 3'b100;

    logic             valid_reg;
    logic             regwrite_reg;
    logic [4:0]       rd_reg;
    logic [31:0]      wd_reg;
    logic             misalign_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [1:0]  byte_off;
    logic [7:0]  byte_lane [4];
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] wd_next;
    logic        misalign_next;
    logic        freeze;
    logic        advance;

    // Only the debug-pause switch matters here; the rest of the bank is ignored.
    logic unused_sw;
    assign unused_sw = ^{sw_i[15:2], sw_i[0]};

    assign byte_off = in_alu[1:0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = in_mem_word[8*gi +: 8];
        end
    endgenerate

    assign load_byte = byte_lane[byte_off];
    assign load_half = in_alu[1] ? in_mem_word[31:16] : in_mem_word[15:0];

    // Unlisted DMType encodings fall through to a full-word load.
    always_comb begin
        load_data = in_mem_word;
        case (in_DMType)
            DM_LH:   load_data = {{16{load_half[15]}}, load_half};
            DM_LHU:  load_data = {16'h0000, load_half};
            DM_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            DM_LBU:  load_data = {24'h000000, load_byte};
            default: load_data = in_mem_word;
        endcase
    end

    always_comb begin
        wd_next = in_alu;
        case (in_WDSel)
            WDSEL_MEM: wd_next = load_data;
            WDSEL_PC4: wd_next = in_pc + 32'd4;
            default:   wd_next = in_alu;
        endcase
    end

    always_comb begin
        misalign_next = 1'b0;
        if (in_WDSel == WDSEL_MEM) begin
            case (in_DMType)
                DM_LH, DM_LHU: misalign_next = byte_off[0];
                DM_LB, DM_LBU: misalign_next = 1'b0;
                default:       misalign_next = (byte_off != 2'b00);
            endcase
        end
    end

    // A flush overrides a stall, so the held instruction still leaves the stage.
    assign freeze  = sw_i[1];
    assign advance = !freeze && (flush || !stall);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_reg    <= 1'b0;
            regwrite_reg <= 1'b0;
            rd_reg       <= 5'd0;
            wd_reg       <= 32'd0;
            misalign_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            if (valid_reg && advance)
                cnt_reg <= cnt_reg + CNT_W'(1);
            if (!freeze) begin
                if (flush) begin
                    valid_reg    <= 1'b0;
                    regwrite_reg <= 1'b0;
                    rd_reg       <= 5'd0;
                    wd_reg       <= 32'd0;
                    misalign_reg <= 1'b0;
                end else if (!stall) begin
                    valid_reg    <= in_valid;
                    regwrite_reg <= in_RegWrite;
                    rd_reg       <= in_rd;
                    wd_reg       <= wd_next;
                    misalign_reg <= misalign_next;
                end
            end
        end
    end

    assign RFWr       = valid_reg && regwrite_reg && (rd_reg != 5'd0);
    assign A3         = rd_reg;
    assign WD         = wd_reg;
    assign wb_valid   = valid_reg;
    assign misalign   = misalign_reg;
    assign retire_cnt = cnt_reg;

    assign fwd_en   = RFWr;
    assign fwd_rd   = A3;
    assign fwd_data = WD;

endmodule
